e_mdu_iter: RTL and testbench

- Parametrised, iterative multiply/divide unit for the EX stage. Successor to the fixed-latency behavioural MDU.
- Performs real shift-add multiplication and restoring division, one bit per cycle, over WIDTH-bit operands.
- Adds multiply-accumulate/subtract ops, defined divide-by-zero and overflow results, and a done pulse.
- Owns the HI/LO architectural registers. Stall logic in the pipeline uses busy and start.

---
 rtl/e_mdu_iter.sv | 231 +++++++++++++++++++++++
 tb/tb_e_mdu_iter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_iter.sv
// ---------------------------------------------------------------------------
// e_mdu_iter - iterative multiply/divide unit for the EX stage.
//
// This unit computes one bit per cycle. Multiplication uses shift-add.
// Division uses restoring shift-subtract. Both work on WIDTH-bit operands.
// The unit also supports multiply-accumulate and multiply-subtract into
// HI/LO. It owns the HI/LO architectural registers.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   req      exception/interrupt request; blocks acceptance of new ops and
//            of mthi/mtlo in this cycle
//   mduOp    operation: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//            6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 nop
//   d1       rs operand (dividend / multiplicand / mthi-mtlo source)
//   d2       rt operand (divisor / multiplier)
//   start    issue strobe for the iterative ops (1-4, 7-10)
//   busy     an operation is in flight
//   done     one-cycle pulse in the cycle whose closing edge writes hi/lo
//   hi, lo   HI and LO registers
// ---------------------------------------------------------------------------
module e_mdu_iter #(
  parameter int WIDTH   = 32,
  parameter bit EN_MACC = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [3:0]       mduOp,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] acc_reg, acc_next;   // product high half / partial remainder
  logic [WIDTH-1:0] q_reg, q_next;       // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] b_reg, b_next;       // multiplicand or divisor magnitude
  logic             is_div_reg, is_div_next;
  logic             is_macc_reg, is_macc_next;
  logic             is_sub_reg, is_sub_next;
  logic             neg_res_reg, neg_res_next;   // product/quotient must be negated
  logic             neg_rem_reg, neg_rem_next;   // remainder takes the dividend's sign
  logic             div0_reg, div0_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;

  // Operation decode. When EN_MACC is 0, the accumulate ops decode to
  // nothing, so they fall through as nops.
  logic op_mul, op_div, op_macc, op_sub, op_signed, op_start;

  always_comb begin
    op_mul    = 1'b0;
    op_div    = 1'b0;
    op_macc   = 1'b0;
    op_sub    = 1'b0;
    op_signed = 1'b0;
    case (mduOp)
      OP_MULT:  begin op_mul = 1'b1; op_signed = 1'b1; end
      OP_MULTU: op_mul = 1'b1;
      OP_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  op_div = 1'b1;
      OP_MADD:  begin op_mul = EN_MACC; op_macc = EN_MACC; op_signed = EN_MACC; end
      OP_MADDU: begin op_mul = EN_MACC; op_macc = EN_MACC; end
      OP_MSUB:  begin op_mul = EN_MACC; op_macc = EN_MACC; op_sub = EN_MACC; op_signed = EN_MACC; end
      OP_MSUBU: begin op_mul = EN_MACC; op_macc = EN_MACC; op_sub = EN_MACC; end
      default:  ;
    endcase
  end

  assign op_start = op_mul | op_div;

  // Signed ops iterate on magnitudes. -2^(WIDTH-1) maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit value.
  logic             d1_neg, d2_neg;
  logic [WIDTH-1:0] d1_mag, d2_mag;

  assign d1_neg = op_signed & d1[WIDTH-1];
  assign d2_neg = op_signed & d2[WIDTH-1];
  assign d1_mag = d1_neg ? -d1 : d1;
  assign d2_mag = d2_neg ? -d2 : d2;

  // One multiply step: conditionally add the multiplicand, then shift
  // {acc,q} right. The carry out of the add re-enters acc at the top.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_reg} + {1'b0, (q_reg[0] ? b_reg : {WIDTH{1'b0}})};

  // One restoring divide step. The trial value is WIDTH+1 bits wide,
  // because the shifted remainder can momentarily exceed WIDTH bits.
  // When the subtraction succeeds, the difference is below the divisor,
  // so its low WIDTH bits are exact.
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  assign div_trial = {acc_reg, q_reg[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, b_reg});
  assign div_diff  = div_trial[WIDTH-1:0] - b_reg;

  // Final result with sign correction. The most-negative / -1 overflow
  // case needs no special handling: the magnitude quotient 2^(WIDTH-1) is
  // left un-negated, which already reads as -2^(WIDTH-1), and the remainder
  // is 0. Divide by zero leaves the remainder equal to |d1|. Giving it the
  // dividend's sign restores d1 exactly, so only the quotient is forced.
  logic [2*WIDTH-1:0] prod_mag, prod_res, result, hilo_cur, hilo_new;
  logic [WIDTH-1:0]   quot_res, rem_res;

  assign prod_mag = {acc_reg, q_reg};
  assign prod_res = neg_res_reg ? -prod_mag : prod_mag;
  assign quot_res = div0_reg ? {WIDTH{1'b1}} : (neg_res_reg ? -q_reg : q_reg);
  assign rem_res  = neg_rem_reg ? -acc_reg : acc_reg;
  assign result   = is_div_reg ? {rem_res, quot_res} : prod_res;
  assign hilo_cur = {hi_reg, lo_reg};
  assign hilo_new = !is_macc_reg ? result :
                    (is_sub_reg ? (hilo_cur - result) : (hilo_cur + result));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    q_next       = q_reg;
    b_next       = b_reg;
    is_div_next  = is_div_reg;
    is_macc_next = is_macc_reg;
    is_sub_next  = is_sub_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    div0_next    = div0_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && !req && op_start) begin
          state_next   = S_RUN;
          cnt_next     = CW'(WIDTH);
          acc_next     = '0;
          b_next       = op_mul ? d1_mag : d2_mag;
          q_next       = op_mul ? d2_mag : d1_mag;
          is_div_next  = op_div;
          is_macc_next = op_macc;
          is_sub_next  = op_sub;
          neg_res_next = d1_neg ^ d2_neg;
          neg_rem_next = d1_neg;
          div0_next    = op_div & (d2 == '0);
        end else if (!req && mduOp == OP_MTHI) begin
          hi_next = d1;
        end else if (!req && mduOp == OP_MTLO) begin
          lo_next = d1;
        end
      end
      S_RUN: begin
        if (is_div_reg) begin
          acc_next = div_ge ? div_diff : div_trial[WIDTH-1:0];
          q_next   = {q_reg[WIDTH-2:0], div_ge};
        end else begin
          acc_next = mul_sum[WIDTH:1];
          q_next   = {mul_sum[0], q_reg[WIDTH-1:1]};
        end
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        {hi_next, lo_next} = hilo_new;
        state_next         = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      b_reg       <= '0;
      is_div_reg  <= 1'b0;
      is_macc_reg <= 1'b0;
      is_sub_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      q_reg       <= q_next;
      b_reg       <= b_next;
      is_div_reg  <= is_div_next;
      is_macc_reg <= is_macc_next;
      is_sub_reg  <= is_sub_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      div0_reg    <= div0_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  // All outputs come straight from registers.
  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_FIX);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_e_mdu_iter.sv
// ---------------------------------------------------------------------------
// tb_e_mdu_iter - self-checking bench for e_mdu_iter.
// This bench instantiates two units: a 32-bit unit with MACC enabled, and
// an 8-bit unit with MACC disabled. It checks results against a plain
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_e_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        req, start, busy, done;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        req8, start8, busy8, done8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu_iter #(.WIDTH(32), .EN_MACC(1'b1)) dut (
    .clk(clk), .reset_n(rst_n), .req(req), .mduOp(op), .d1(a), .d2(b),
    .start(start), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  e_mdu_iter #(.WIDTH(8), .EN_MACC(1'b0)) dut8 (
    .clk(clk), .reset_n(rst_n), .req(req8), .mduOp(op8), .d1(a8), .d2(b8),
    .start(start8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Reference model: the resulting {hi,lo} in the low 2*w bits (w is 8 or 32).
  function automatic logic [63:0] model(input int w, input bit en, input logic [3:0] o,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] h, input logic [31:0] l);
    logic [63:0] mw, m2, ux, uy, acc, p, res;
    longint      sxv, syv;
    logic [7:0]  x8, y8;
    mw  = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
    m2  = (w == 32) ? '1 : 64'hFFFF;
    x8  = x[7:0];
    y8  = y[7:0];
    ux  = {32'd0, x} & mw;
    uy  = {32'd0, y} & mw;
    sxv = (w == 32) ? longint'($signed(x)) : longint'($signed(x8));
    syv = (w == 32) ? longint'($signed(y)) : longint'($signed(y8));
    acc = ((({32'd0, h}) & mw) << w) | ({32'd0, l} & mw);
    p   = (o inside {4'd1, 4'd3, 4'd7, 4'd9}) ? 64'(sxv * syv) : ux * uy;
    res = acc;
    case (o)
      4'd1, 4'd2: res = p;
      4'd3: begin
        if (uy == 0) res = (ux << w) | mw;
        else if (sxv == -(longint'(1) << (w - 1)) && syv == -1) res = 64'd1 << (w - 1);
        else res = (((64'(sxv % syv)) & mw) << w) | ((64'(sxv / syv)) & mw);
      end
      4'd4: begin
        if (uy == 0) res = (ux << w) | mw;
        else res = ((ux % uy) << w) | (ux / uy);
      end
      4'd5:        res = (ux << w) | ({32'd0, l} & mw);
      4'd6:        res = (acc & ~mw) | ux;
      4'd7, 4'd8:  if (en) res = acc + p;
      4'd9, 4'd10: if (en) res = acc - p;
      default: ;
    endcase
    return res & m2;
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // This task issues one op with start=1. It then follows busy until busy
  // falls. It reports the busy cycles, the done pulses, and whether hi/lo
  // held their values while busy.
  task automatic exec(input bit w8, input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, output int bcyc, output int dcnt, output bit hold);
    logic [31:0] h0, l0;
    @(negedge clk);
    if (w8) begin op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
    else    begin op  = o; a  = x;      b  = y;      start  = 1'b1; end
    h0 = w8 ? {24'd0, hi8} : hi;
    l0 = w8 ? {24'd0, lo8} : lo;
    @(posedge clk); #1;
    start = 1'b0; start8 = 1'b0; op = 4'd0; op8 = 4'd0;
    bcyc = 0; dcnt = 0; hold = 1'b1;
    while ((w8 ? busy8 : busy) && bcyc < 200) begin
      bcyc++;
      if (w8 ? done8 : done) dcnt++;
      if ((w8 ? {24'd0, hi8} : hi) !== h0 || (w8 ? {24'd0, lo8} : lo) !== l0) hold = 1'b0;
      @(posedge clk); #1;
    end
    if (w8 ? done8 : done) dcnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
    req8 = 1'b0; start8 = 1'b0; op8 = 4'd0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
    n_checks++; if ({busy8, done8, hi8, lo8} !== 18'd0) begin
      n_fail++; $display("FAIL reset_dut8 got=%b%b %h %h exp=all zero", busy8, done8, hi8, lo8);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    m_hi = '0; m_lo = '0;
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [31:0] x, y, eh, el;
  } vec_t;

  // The directed table uses hand-derived results, including the mthi/mtlo
  // plus MACC sequence.
  vec_t dir_tab[14] = '{
    '{4'd1,  32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{4'd2,  32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE},
    '{4'd3,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD},
    '{4'd4,  32'd100,       32'd7,          32'd2,         32'd14},
    '{4'd3,  32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF},
    '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000},
    '{4'd3,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF},
    '{4'd3,  32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD},
    '{4'd1,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0},
    '{4'd5,  32'd0,         32'd0,          32'd0,         32'd0},
    '{4'd6,  32'd10,        32'd0,          32'd0,         32'd10},
    '{4'd7,  32'd3,         32'd4,          32'd0,         32'd22},
    '{4'd10, 32'd0,         32'd0,          32'd0,         32'd22},
    '{4'd9,  32'd5,         32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFFD}
  };

  task automatic test_directed();
    int bc, dc, ebc;
    bit hold;
    foreach (dir_tab[i]) begin
      exec(1'b0, dir_tab[i].o, dir_tab[i].x, dir_tab[i].y, bc, dc, hold);
      ebc = (dir_tab[i].o inside {[4'd1:4'd4], [4'd7:4'd10]}) ? 33 : 0;
      $display("directed op=%0d d1=%h d2=%h -> hi=%h lo=%h busy_cycles=%0d done=%0d",
               dir_tab[i].o, dir_tab[i].x, dir_tab[i].y, hi, lo, bc, dc);
      n_checks++; if (hi !== dir_tab[i].eh) begin n_fail++; $display("FAIL dir_hi[%0d] got=%h exp=%h", i, hi, dir_tab[i].eh); end
      n_checks++; if (lo !== dir_tab[i].el) begin n_fail++; $display("FAIL dir_lo[%0d] got=%h exp=%h", i, lo, dir_tab[i].el); end
      n_checks++; if (bc !== ebc) begin n_fail++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, bc, ebc); end
      n_checks++; if (dc !== (ebc != 0 ? 1 : 0)) begin n_fail++; $display("FAIL dir_done[%0d] got=%0d exp=%0d", i, dc, (ebc != 0 ? 1 : 0)); end
      n_checks++; if (!hold) begin n_fail++; $display("FAIL dir_hold[%0d] got=changed exp=held while busy", i); end
      m_hi = dir_tab[i].eh; m_lo = dir_tab[i].el;
    end
  endtask

  task automatic test_req_block();
    @(negedge clk);
    op = 4'd1; a = 32'd3; b = 32'd3; start = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_start_busy got=%b exp=0", busy); end
    @(negedge clk);
    op = 4'd6; a = 32'h1234; start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (lo !== m_lo) begin n_fail++; $display("FAIL req_mtlo_lo got=%h exp=%h", lo, m_lo); end
    @(negedge clk);
    op = 4'd5; a = 32'h5678;
    @(posedge clk); #1;
    n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL req_mthi_hi got=%h exp=%h", hi, m_hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_busy_after got=%b exp=0", busy); end
    op = 4'd0; req = 1'b0;
    $display("req_block hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_busy_ignore();
    int bc = 0;
    @(negedge clk);
    op = 4'd4; a = 32'd1000; b = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    while (busy && bc < 200) begin
      bc++;
      if (bc == 5) begin op = 4'd6; a = 32'hDEAD; start = 1'b1; end
      if (bc == 8) begin op = 4'd1; a = 32'd9; b = 32'd9; end
      if (bc == 20) begin op = 4'd5; req = 1'b1; end
      @(posedge clk); #1;
    end
    start = 1'b0; op = 4'd0; req = 1'b0;
    $display("busy_ignore divu 1000/10 -> hi=%h lo=%h busy_cycles=%0d", hi, lo, bc);
    n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL busy_ignore_latency got=%0d exp=33", bc); end
    n_checks++; if (lo !== 32'd100) begin n_fail++; $display("FAIL busy_ignore_lo got=%h exp=%h", lo, 32'd100); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL busy_ignore_hi got=%h exp=0", hi); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle got=%b exp=0", busy); end
    m_hi = 32'd0; m_lo = 32'd100;
  endtask

  // Random ops are issued back to back: each one starts in the first cycle
  // after the previous one drops busy.
  task automatic test_random_back_to_back();
    logic [3:0]  ops[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
    logic [3:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    int          bc, dc, ebc;
    bit          hold;
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 11)];
      x = rnd();
      y = rnd();
      e = model(32, 1'b1, o, x, y, m_hi, m_lo);
      exec(1'b0, o, x, y, bc, dc, hold);
      ebc = (o inside {[4'd1:4'd4], [4'd7:4'd10]}) ? 33 : 0;
      $display("random op=%0d d1=%h d2=%h -> hi=%h lo=%h busy_cycles=%0d", o, x, y, hi, lo, bc);
      n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL rand_hilo[%0d] op=%0d got=%h_%h exp=%h_%h", i, o, hi, lo, e[63:32], e[31:0]); end
      n_checks++; if (bc !== ebc) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, bc, ebc); end
      n_checks++; if (dc !== (ebc != 0 ? 1 : 0)) begin n_fail++; $display("FAIL rand_done[%0d] got=%0d exp=%0d", i, dc, (ebc != 0 ? 1 : 0)); end
      n_checks++; if (!hold) begin n_fail++; $display("FAIL rand_hold[%0d] got=changed exp=held while busy", i); end
      m_hi = e[63:32]; m_lo = e[31:0];
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc;
    bit hold;
    exec(1'b0, 4'd5, 32'h55, 32'd0, bc, dc, hold);
    exec(1'b0, 4'd6, 32'hAA, 32'd0, bc, dc, hold);
    n_checks++; if ({hi, lo} !== {32'h55, 32'hAA}) begin n_fail++; $display("FAIL rstmid_pre got=%h_%h exp=00000055_000000aa", hi, lo); end
    @(negedge clk);
    op = 4'd3; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    repeat (9) @(posedge clk);
    #2;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_inflight got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    $display("reset_mid busy=%b hi=%h lo=%h", busy, hi, lo);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({busy, done, hi, lo} !== 66'd0) begin n_fail++; $display("FAIL rstmid_after got=%b%b %h %h exp=all zero", busy, done, hi, lo); end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_w8_nomacc();
    logic [3:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    logic [7:0]  h8, l8;
    int          bc, dc;
    bit          hold;
    h8 = 8'd0; l8 = 8'd0;
    exec(1'b1, 4'd1, 32'h80, 32'h80, bc, dc, hold);
    $display("w8 mult 80*80 -> hi=%h lo=%h busy_cycles=%0d", hi8, lo8, bc);
    n_checks++; if ({hi8, lo8} !== 16'h4000) begin n_fail++; $display("FAIL w8_mult got=%h_%h exp=40_00", hi8, lo8); end
    n_checks++; if (bc !== 9) begin n_fail++; $display("FAIL w8_latency got=%0d exp=9", bc); end
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL w8_done got=%0d exp=1", dc); end
    exec(1'b1, 4'd7, 32'd3, 32'd4, bc, dc, hold);
    $display("w8 madd 3*4 -> hi=%h lo=%h busy_cycles=%0d", hi8, lo8, bc);
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL w8_madd_busy got=%0d exp=0", bc); end
    n_checks++; if ({hi8, lo8} !== 16'h4000) begin n_fail++; $display("FAIL w8_madd_hilo got=%h_%h exp=40_00", hi8, lo8); end
    h8 = 8'h40; l8 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      o = 4'($urandom_range(1, 10));
      if (o == 4'd5 || o == 4'd6) o = 4'd3;
      x = (i == 0) ? 32'h80 : 32'($urandom_range(0, 255));
      y = (i == 0) ? 32'hFF : ((i % 4 == 1) ? 32'd0 : 32'($urandom_range(0, 255)));
      e = model(8, 1'b0, o, x, y, {24'd0, h8}, {24'd0, l8});
      exec(1'b1, o, x, y, bc, dc, hold);
      $display("w8 random op=%0d d1=%h d2=%h -> hi=%h lo=%h busy_cycles=%0d", o, x[7:0], y[7:0], hi8, lo8, bc);
      n_checks++; if ({hi8, lo8} !== e[15:0]) begin n_fail++; $display("FAIL w8_rand[%0d] op=%0d got=%h_%h exp=%h", i, o, hi8, lo8, e[15:0]); end
      n_checks++; if (bc !== ((o <= 4'd4) ? 9 : 0)) begin n_fail++; $display("FAIL w8_rand_latency[%0d] got=%0d exp=%0d", i, bc, ((o <= 4'd4) ? 9 : 0)); end
      h8 = e[15:8]; l8 = e[7:0];
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_req_block();
    test_busy_ignore();
    test_random_back_to_back();
    test_reset_mid();
    test_w8_nomacc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
